// File: rtl/uart_alu_intf_pkg.sv
// Shared definitions for the UART-ALU frame controller: FSM state encoding and
// default sizing constants.
package uart_alu_intf_pkg;

  localparam int DEF_DBIT    = 8;
  localparam int DEF_TIMEOUT = 1_000_000;
  localparam int DEF_TMR_W   = 20;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SEND   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_alu_intf_timer.sv
// Inter-byte timeout counter: expire is high once TIMEOUT-1 idle clocks have
// accumulated since the last clear.
module frame_timer
  import uart_alu_intf_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TMR_W   = DEF_TMR_W
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] r_count;

  // Idle counter; saturates at LAST so a stalled owner never wraps it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != LAST)) begin
      r_count <= r_count + TMR_W'(1);
    end
  end

  assign expire = (r_count == LAST);

endmodule

// File: rtl/uart_alu_intf.sv
// Frame controller: pops A, B, OP from the RX FIFO, presents them to the ALU,
// and pushes the ALU result into the TX FIFO.
module uart_alu_intf
  import uart_alu_intf_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TMR_W   = DEF_TMR_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic [DBIT-1:0] alu_a,
  output logic [DBIT-1:0] alu_b,
  output logic [DBIT-1:0] alu_op,
  input  logic [DBIT-1:0] alu_result,
  output logic            frame_err,
  output logic            busy
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DBIT-1:0] r_alu_a;
  logic [DBIT-1:0] r_alu_b;
  logic [DBIT-1:0] r_alu_op;
  logic [DBIT-1:0] r_w_data;
  logic            r_frame_err;
  logic            w_pop;
  logic            w_push;
  logic            w_abort;
  logic            w_expire;
  logic            w_tmr_en;
  logic            w_tmr_clr;

  // Next-state and FIFO handshake decode; a pop always beats a timeout
  always_comb begin
    w_pop       = 1'b0;
    w_push      = 1'b0;
    w_abort     = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      GET_A: begin
        w_pop = ~rx_empty;
        if (w_pop) w_state_nxt = GET_B;
        else       w_state_nxt = GET_A;
      end
      GET_B: begin
        w_pop = ~rx_empty;
        if (w_pop) begin
          w_state_nxt = GET_OP;
        end else if (w_expire) begin
          w_abort     = 1'b1;
          w_state_nxt = GET_A;
        end else begin
          w_state_nxt = GET_B;
        end
      end
      GET_OP: begin
        w_pop = ~rx_empty;
        if (w_pop) begin
          w_state_nxt = EXEC;
        end else if (w_expire) begin
          w_abort     = 1'b1;
          w_state_nxt = GET_A;
        end else begin
          w_state_nxt = GET_OP;
        end
      end
      EXEC: begin
        w_state_nxt = SEND;
      end
      SEND: begin
        w_push = ~tx_full;
        if (w_push) w_state_nxt = GET_A;
        else        w_state_nxt = SEND;
      end
      default: begin
        w_state_nxt = GET_A;
      end
    endcase
  end

  assign w_tmr_en  = ((r_state == GET_B) || (r_state == GET_OP)) && !w_pop;
  assign w_tmr_clr = w_pop || (w_state_nxt == GET_A);

  frame_timer #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_frame_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (w_tmr_en),
    .clr    (w_tmr_clr),
    .expire (w_expire)
  );

  // State, operand capture and result latch; operands move only on their own pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= GET_A;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_w_data    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_err <= w_abort;
      if (w_pop && (r_state == GET_A))  r_alu_a  <= r_data;
      if (w_pop && (r_state == GET_B))  r_alu_b  <= r_data;
      if (w_pop && (r_state == GET_OP)) r_alu_op <= r_data;
      if (r_state == EXEC)              r_w_data <= alu_result;
    end
  end

  // Handshakes are gated by reset so nothing moves while the block is held
  assign rd_uart   = reset & w_pop;
  assign wr_uart   = reset & w_push;
  assign w_data    = r_w_data;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != GET_A);

endmodule
